// File: rtl/avl_cmd_pipe_if.sv
// Avalon-MM command/response bundle shared by the upstream bridge side and the
// controller side of avl_cmd_pipe.
interface avl_cmd_pipe_if #(
  parameter int DW = 32,
  parameter int AW = 28,
  parameter int BW = 6
);
  logic [AW-1:0]   address;
  logic [BW-1:0]   burstcount;
  logic [DW/8-1:0] byteenable;
  logic [DW-1:0]   writedata;
  logic            read;
  logic            write;
  logic            waitrequest;
  logic [DW-1:0]   readdata;
  logic            readdatavalid;

  modport master (
    output address, burstcount, byteenable, writedata, read, write,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, burstcount, byteenable, writedata, read, write,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/avl_cmd_pipe.sv
// Avalon-MM pipeline stage: 2-entry skid-buffered command path, read-beat credit
// gate, in-order response path. AVL_CMD_PIPE_RSP_REG_EN registers the response path.
module avl_cmd_pipe #(
  parameter int DW          = 32,
  parameter int AW          = 28,
  parameter int BW          = 6,
  parameter int MAX_PENDING = 32
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n_i,
  avl_cmd_pipe_if.slave   s,
  avl_cmd_pipe_if.master  m,
  output logic            rsp_overflow_o
);
  localparam int BEW = DW / 8;
  localparam int PW  = $clog2(MAX_PENDING + 1);
  localparam int SW  = ((PW > BW) ? PW : BW) + 1;

  typedef struct packed {
    logic [AW-1:0]  address;
    logic [BW-1:0]  burstcount;
    logic [BEW-1:0] byteenable;
    logic [DW-1:0]  writedata;
    logic           read;
    logic           write;
  } cmd_t;

  cmd_t          up_cmd;
  cmd_t          main_reg;
  cmd_t          skid_reg;
  logic          main_valid_reg;
  logic          skid_valid_reg;
  logic [PW-1:0] pending_reg;
  logic [PW-1:0] pending_next;
  logic          accept;
  logic          drain;
  logic          credit_ok;
  logic          rd_issue;
  logic          rd_return;
  logic [SW-1:0] inc_beats;

  always_comb begin
    up_cmd            = '0;
    up_cmd.address    = s.address;
    up_cmd.burstcount = s.burstcount;
    up_cmd.byteenable = s.byteenable;
    up_cmd.writedata  = s.writedata;
    up_cmd.read       = s.read;
    up_cmd.write      = s.write;
  end

  // The skid entry is only ever valid while main is occupied, so waitrequest
  // can come straight from a flop.
  assign s.waitrequest = skid_valid_reg;
  assign accept        = (s.read | s.write) & ~skid_valid_reg;

  assign credit_ok    = (SW'(pending_reg) + SW'(main_reg.burstcount)) <= SW'(MAX_PENDING);
  assign m.address    = main_reg.address;
  assign m.burstcount = main_reg.burstcount;
  assign m.byteenable = main_reg.byteenable;
  assign m.writedata  = main_reg.writedata;
  assign m.write      = main_valid_reg & main_reg.write;
  assign m.read       = main_valid_reg & main_reg.read & credit_ok;
  assign drain        = (m.read | m.write) & ~m.waitrequest;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      main_reg       <= '0;
      skid_reg       <= '0;
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else begin
      if (drain || !main_valid_reg) begin
        if (skid_valid_reg) begin
          main_reg       <= skid_reg;
          main_valid_reg <= 1'b1;
        end else if (accept) begin
          main_reg       <= up_cmd;
          main_valid_reg <= 1'b1;
        end else begin
          main_valid_reg <= 1'b0;
        end
      end
      if (accept && main_valid_reg && !drain) begin
        skid_reg       <= up_cmd;
        skid_valid_reg <= 1'b1;
      end else if (drain) begin
        skid_valid_reg <= 1'b0;
      end
    end
  end

  // Returned beats with nothing outstanding are not counted, only flagged.
  assign rd_issue     = m.read & ~m.waitrequest;
  assign rd_return    = m.readdatavalid & (pending_reg != '0);
  assign inc_beats    = rd_issue ? SW'(main_reg.burstcount) : '0;
  assign pending_next = PW'(SW'(pending_reg) + inc_beats - SW'(rd_return));

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      pending_reg    <= '0;
      rsp_overflow_o <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      if (m.readdatavalid && (pending_reg == '0)) begin
        rsp_overflow_o <= 1'b1;
      end
    end
  end

`ifdef AVL_CMD_PIPE_RSP_REG_EN
  logic          rsp_valid_reg;
  logic [DW-1:0] rsp_data_reg;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
    end else begin
      rsp_valid_reg <= m.readdatavalid;
      if (m.readdatavalid) begin
        rsp_data_reg <= m.readdata;
      end
    end
  end

  assign s.readdatavalid = rsp_valid_reg;
  assign s.readdata      = rsp_data_reg;
`else
  assign s.readdatavalid = m.readdatavalid;
  assign s.readdata      = m.readdata;
`endif
endmodule
